// File: rtl/arcade_cen_pkg.sv
// Shared constants for the arcade clock-enable generator: default channel
// count, accumulator width and the 48 MHz master reset ratios.
package arcade_cen_pkg;

  localparam int CEN_NCH  = 5;
  localparam int CEN_ACCW = 8;

  // ch0 in the LSBs: 24M, 12M, 6M, 3M enables and an 8M toggle from 48M
  localparam logic [CEN_NCH*CEN_ACCW-1:0] CEN_DEF_NUM = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
  localparam logic [CEN_NCH*CEN_ACCW-1:0] CEN_DEF_DEN = {8'd3, 8'd8, 8'd4, 8'd2, 8'd1};

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int cen_ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/cen_frac_div.sv
// One fractional clock-enable channel: N/D phase accumulator producing a
// one-cycle enable per overflow, a toggle output and its edge-qualified enables.
module cen_frac_div #(
  parameter int              ACCW    = 8,
  parameter logic [ACCW-1:0] RST_NUM = 1,
  parameter logic [ACCW-1:0] RST_DEN = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_run,
  input  logic            i_resync,
  input  logic            i_cfg_we,
  input  logic [ACCW-1:0] i_cfg_num,
  input  logic [ACCW-1:0] i_cfg_den,
  output logic            o_cen,
  output logic            o_clkout,
  output logic            o_cen_p,
  output logic            o_cen_n
);

  logic [ACCW-1:0] r_num, r_den, r_acc;
  logic            r_cen, r_clk, r_cen_p, r_cen_n;

  logic            w_active;
  logic [ACCW-1:0] w_num_eff;
  logic [ACCW:0]   w_sum;
  logic            w_ovf;
  logic [ACCW-1:0] w_acc_upd;

  // Accumulate step with the current ratio; numerator clamped so at most one overflow per edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_active  = i_run && (r_num != '0) && (r_den != '0);
    w_num_eff = (r_num > r_den) ? r_den : r_num;
    w_sum     = {1'b0, r_acc} + {1'b0, w_num_eff};
    w_ovf     = w_active && (w_sum >= {1'b0, r_den});
    w_acc_upd = r_acc;
    if (w_active) begin
      // The true remainder always fits ACCW bits, so modular subtraction is exact.
      w_acc_upd = w_ovf ? (w_sum[ACCW-1:0] - r_den) : w_sum[ACCW-1:0];
    end
  end

  // Ratio registers, accumulator and registered enable/toggle outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      r_num   <= RST_NUM;
      r_den   <= RST_DEN;
      r_acc   <= '0;
      r_cen   <= 1'b0;
      r_clk   <= 1'b0;
      r_cen_p <= 1'b0;
      r_cen_n <= 1'b0;
    end else begin
      if (i_cfg_we) begin
        r_num <= i_cfg_num;
        r_den <= i_cfg_den;
      end
      if (i_resync) begin
        r_acc   <= '0;
        r_clk   <= 1'b0;
        r_cen   <= 1'b0;
        r_cen_p <= 1'b0;
        r_cen_n <= 1'b0;
      end else begin
        r_cen   <= w_ovf;
        r_cen_p <= w_ovf & ~r_clk;
        r_cen_n <= w_ovf &  r_clk;
        if (w_ovf) r_clk <= ~r_clk;
        // A shrinking denominator must never leave the phase at or above it.
        if (i_cfg_we && (i_cfg_den != '0) && (w_acc_upd >= i_cfg_den)) r_acc <= '0;
        else                                                          r_acc <= w_acc_upd;
      end
    end
  end

  assign o_cen    = r_cen;
  assign o_clkout = r_clk;
  assign o_cen_p  = r_cen_p;
  assign o_cen_n  = r_cen_n;

endmodule

// File: rtl/arcade_cen_gen.sv
// Multi-channel fractional clock-enable generator: decodes ratio writes to
// per-channel strobes and fans run/resync out to NCH cen_frac_div channels.
module arcade_cen_gen
  import arcade_cen_pkg::*;
#(
  parameter int                       NCH     = CEN_NCH,
  parameter int                       ACCW    = CEN_ACCW,
  parameter logic [NCH*ACCW-1:0]      DEF_NUM = CEN_DEF_NUM,
  parameter logic [NCH*ACCW-1:0]      DEF_DEN = CEN_DEF_DEN,
  localparam int                      CHW     = cen_ch_width(NCH)
) (
  input  logic            clk48M,
  input  logic            reset,
  input  logic            run,
  input  logic            resync,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [ACCW-1:0] cfg_num,
  input  logic [ACCW-1:0] cfg_den,
  output logic [NCH-1:0]  cen,
  output logic [NCH-1:0]  clkout,
  output logic [NCH-1:0]  cen_p,
  output logic [NCH-1:0]  cen_n
);

  logic [NCH-1:0] w_cfg_we;

  // One-hot write strobe; indices at or beyond NCH select nothing.
  always_comb begin
    w_cfg_we = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (32'(cfg_ch) == i)) w_cfg_we[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cen_frac_div #(
      .ACCW    (ACCW),
      .RST_NUM (DEF_NUM[g*ACCW +: ACCW]),
      .RST_DEN (DEF_DEN[g*ACCW +: ACCW])
    ) u_div (
      .i_clk     (clk48M),
      .i_reset   (reset),
      .i_run     (run),
      .i_resync  (resync),
      .i_cfg_we  (w_cfg_we[g]),
      .i_cfg_num (cfg_num),
      .i_cfg_den (cfg_den),
      .o_cen     (cen[g]),
      .o_clkout  (clkout[g]),
      .o_cen_p   (cen_p[g]),
      .o_cen_n   (cen_n[g])
    );
  end

endmodule

// File: tb/tb_arcade_cen_gen.sv
// Self-checking bench for arcade_cen_gen: reset-release vector table,
// hand-written corner sequences and randomized traffic against a ratio model.
module tb_arcade_cen_gen;

  localparam int NCH = 5;

  logic       clk48M = 1'b0;
  logic       reset  = 1'b1;
  logic       run    = 1'b0;
  logic       resync = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_num = '0;
  logic [7:0] cfg_den = '0;
  logic [NCH-1:0] cen, clkout, cen_p, cen_n;

  arcade_cen_gen dut (
    .clk48M (clk48M), .reset (reset), .run (run), .resync (resync),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_num (cfg_num), .cfg_den (cfg_den),
    .cen (cen), .clkout (clkout), .cen_p (cen_p), .cen_n (cen_n)
  );

  always #5 clk48M = ~clk48M;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ratio model: each channel holds a phase in [0, den); one step adds the
  // clamped numerator and the number of whole denominators crossed is the
  // number of enables (at most one).
  const int def_den[NCH] = '{1, 2, 4, 8, 3};
  int             m_num[NCH];
  int             m_den[NCH];
  int             m_phase[NCH];
  logic [NCH-1:0] m_cen = '0;
  logic [NCH-1:0] m_clk = '0;

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int inc, total;
      if (reset) begin
        m_num[c] = 1; m_den[c] = def_den[c]; m_phase[c] = 0;
        m_cen[c] = 1'b0; m_clk[c] = 1'b0;
      end else begin
        if (resync) begin
          m_phase[c] = 0; m_cen[c] = 1'b0; m_clk[c] = 1'b0;
        end else begin
          m_cen[c] = 1'b0;
          if (run && m_num[c] > 0 && m_den[c] > 0) begin
            inc   = (m_num[c] < m_den[c]) ? m_num[c] : m_den[c];
            total = m_phase[c] + inc;
            m_cen[c]   = (total / m_den[c]) == 1;
            m_phase[c] = total % m_den[c];
            if (m_cen[c]) m_clk[c] = ~m_clk[c];
          end
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          m_num[c] = int'(cfg_num);
          m_den[c] = int'(cfg_den);
          if (m_den[c] != 0 && m_phase[c] >= m_den[c]) m_phase[c] = 0;
        end
      end
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic step(input string tag);
    @(posedge clk48M);
    model_edge();
    #1;
    check({tag, " cen"},    32'(cen),    32'(m_cen));
    check({tag, " clkout"}, 32'(clkout), 32'(m_clk));
    check({tag, " cen_p"},  32'(cen_p),  32'(m_cen & m_clk));
    check({tag, " cen_n"},  32'(cen_n),  32'(m_cen & ~m_clk));
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [7:0] num, input logic [7:0] den);
    cfg_we = 1'b1; cfg_ch = ch; cfg_num = num; cfg_den = den;
  endtask

  typedef struct {
    logic           run;
    logic           resync;
    logic [NCH-1:0] exp_cen;
    logic [NCH-1:0] exp_clk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Edges after reset release with default ratios (ch4..ch0 = 1/3,1/8,1/4,1/2,1/1)
    vecs[0] = '{1'b1, 1'b0, 5'b00001, 5'b00001};
    vecs[1] = '{1'b1, 1'b0, 5'b00011, 5'b00010};
    vecs[2] = '{1'b1, 1'b0, 5'b10001, 5'b10011};
    vecs[3] = '{1'b1, 1'b0, 5'b00111, 5'b10100};
    vecs[4] = '{1'b1, 1'b0, 5'b00001, 5'b10101};
    vecs[5] = '{1'b1, 1'b0, 5'b10011, 5'b00110};
    vecs[6] = '{1'b1, 1'b0, 5'b00001, 5'b00111};
    vecs[7] = '{1'b1, 1'b0, 5'b01111, 5'b01000};
    vecs[8] = '{1'b1, 1'b1, 5'b00000, 5'b00000};
    vecs[9] = '{1'b1, 1'b0, 5'b00001, 5'b00001};

    // Reset state
    step("rst");
    step("rst");
    check("rst cen const", 32'(cen), 0);
    check("rst clkout const", 32'(clkout), 0);

    // Reset release table
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run = vecs[i].run; resync = vecs[i].resync;
      step("tbl");
      check($sformatf("tbl%0d cen", i),    32'(cen),    32'(vecs[i].exp_cen));
      check($sformatf("tbl%0d clkout", i), 32'(clkout), 32'(vecs[i].exp_clk));
      check($sformatf("tbl%0d cen_p", i),  32'(cen_p),  32'(vecs[i].exp_cen & vecs[i].exp_clk));
      check($sformatf("tbl%0d cen_n", i),  32'(cen_n),  32'(vecs[i].exp_cen & ~vecs[i].exp_clk));
    end

    // ch2 = 3/8 from an aligned start: enables where floor(3e/8) steps
    begin
      int cnt;
      cnt = 0;
      write_cfg(3'd2, 8'd3, 8'd8); resync = 1'b1; run = 1'b1;
      step("r38 cfg");
      cfg_we = 1'b0; resync = 1'b0;
      for (int e = 1; e <= 16; e++) begin
        step("r38");
        check($sformatf("r38 e%0d ch2 cen", e), 32'(cen[2]), 32'(((3*e)/8) != ((3*(e-1))/8)));
        if (cen[2]) cnt++;
      end
      check("r38 cen count", 32'(cnt), 6);
      check("r38 clkout end", 32'(clkout[2]), 0);
    end

    // run low 5 cycles with ch4 at phase 2
    resync = 1'b1; step("pause sync");
    resync = 1'b0; step("pause a1"); step("pause a2");
    check("pause pre ch4 cen", 32'(cen[4]), 0);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("pause low");
      check("pause low cen", 32'(cen), 0);
    end
    run = 1'b1; step("pause resume");
    check("pause resume ch4 cen", 32'(cen[4]), 1);

    // resync after arbitrary activity; ch1 and ch3 both 1/2 afterwards
    write_cfg(3'd3, 8'd1, 8'd2); step("sync cfg"); cfg_we = 1'b0;
    for (int i = 0; i < int'($urandom_range(3, 9)); i++) step("sync pre");
    resync = 1'b1; step("sync");
    check("sync clkout zero", 32'(clkout), 0);
    resync = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step("sync post");
      check($sformatf("sync e%0d ch1 clk", e), 32'(clkout[1]), 32'((e / 2) % 2));
      check($sformatf("sync e%0d ch3 clk", e), 32'(clkout[3]), 32'((e / 2) % 2));
      check($sformatf("sync e%0d ch3 cen", e), 32'(cen[3]), 32'(e % 2 == 0));
    end

    // Boundaries on ch0: num=0, den=0, num>den, out-of-range channel
    write_cfg(3'd0, 8'd0, 8'd5); step("num0 cfg"); cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin step("num0"); check("num0 ch0 cen", 32'(cen[0]), 0); end
    write_cfg(3'd0, 8'd3, 8'd0); step("den0 cfg"); cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin step("den0"); check("den0 ch0 cen", 32'(cen[0]), 0); end
    write_cfg(3'd0, 8'd5, 8'd3); step("clamp cfg"); cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin step("clamp"); check("clamp ch0 cen", 32'(cen[0]), 1); end
    write_cfg(3'd7, 8'd0, 8'd0); step("ch7 cfg");
    check("ch7 edge ch0 cen", 32'(cen[0]), 1);
    cfg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin step("ch7"); check("ch7 ch0 cen", 32'(cen[0]), 1); end

    // den=2 written to ch4 while its phase is 2 -> phase cleared
    write_cfg(3'd4, 8'd1, 8'd3); resync = 1'b1; step("shrink sync");
    cfg_we = 1'b0; resync = 1'b0;
    step("shrink a1"); step("shrink a2");
    run = 1'b0; write_cfg(3'd4, 8'd1, 8'd2); step("shrink cfg");
    cfg_we = 1'b0; run = 1'b1;
    step("shrink e1"); check("shrink e1 ch4 cen", 32'(cen[4]), 0);
    step("shrink e2"); check("shrink e2 ch4 cen", 32'(cen[4]), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      run    = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 49) == 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = 3'($urandom_range(0, 7));
      cfg_num = 8'($urandom_range(0, 12));
      cfg_den = 8'($urandom_range(0, 12));
      step("rnd");
    end
    resync = 1'b0; cfg_we = 1'b0; run = 1'b1;
    for (int i = 0; i < 5; i++) step("rnd tail");

    // Reset mid-stream
    reset = 1'b1; step("mid rst");
    check("mid rst cen", 32'(cen), 0);
    check("mid rst clkout", 32'(clkout), 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step("post rst");
    check("post rst ch3 clk", 32'(clkout[3]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
